// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern pixel stage.
// Holds the default raster size, the RGB444 pixel type, pattern ids and the colour-bar table.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    // Entry [0] is the leftmost bar.
    localparam logic [7:0][11:0] BAR_LUT = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        return rgb444_t'(BAR_LUT[idx]);
    endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// Tracks the pixel position from the active-video windows, counts frames,
// arms rendering after the first full frame boundary and flags over-long lines/frames.
module vga_pixel_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CW       = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_dvalid_h,
    input  logic          i_dvalid_v,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_active,
    output logic          o_armed,
    output logic          o_frame_end,
    output logic [7:0]    o_frame_cnt,
    output logic          o_timing_err
);

    // Counters run one past the last coordinate so an extra pixel/line can be detected.
    localparam logic [CW-1:0] X_END = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_END = CW'(V_ACTIVE);
    localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - 1);

    logic [CW-1:0] r_xcnt;
    logic [CW-1:0] r_ycnt;
    logic          r_dvh_d;
    logic          r_dvv_d;
    logic          r_armed;
    logic [7:0]    r_frame_cnt;
    logic          r_err;

    logic w_active;
    logic w_line_end;
    logic w_frame_end;
    logic w_x_over;
    logic w_y_over;

    assign w_active    = i_dvalid_h & i_dvalid_v;
    assign w_line_end  = r_dvh_d & ~i_dvalid_h;
    assign w_frame_end = r_dvv_d & ~i_dvalid_v;
    assign w_x_over    = w_active & (r_xcnt == X_END);
    assign w_y_over    = w_active & (r_ycnt == Y_END);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_xcnt      <= '0;
            r_ycnt      <= '0;
            r_dvh_d     <= 1'b0;
            r_dvv_d     <= 1'b0;
            r_armed     <= 1'b0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_dvh_d <= i_dvalid_h;
            r_dvv_d <= i_dvalid_v;

            if (!i_dvalid_h) begin
                r_xcnt <= '0;
            end else if (w_active && (r_xcnt != X_END)) begin
                r_xcnt <= r_xcnt + 1'b1;
            end

            if (!i_dvalid_v) begin
                r_ycnt <= '0;
            end else if (w_line_end && (r_ycnt != Y_END)) begin
                r_ycnt <= r_ycnt + 1'b1;
            end

            if (w_frame_end) begin
                r_armed     <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            if (w_x_over || w_y_over) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_x          = (r_xcnt == X_END) ? X_MAX : r_xcnt;
    assign o_y          = (r_ycnt == Y_END) ? Y_MAX : r_ycnt;
    assign o_active     = w_active;
    assign o_armed      = r_armed;
    assign o_frame_end  = w_frame_end;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_timing_err = r_err;

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel stage after the VGA timing generator: renders a frame-latched test pattern as RGB444
// through a two-stage pipeline, with hsync/vsync delayed to stay aligned with the colour.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   CW        = 10,
    parameter int   BAR_W     = 80,
    parameter int   CHECK_BIT = 5,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic          pixelClk,
    input  logic          rst,
    input  logic          hclk,
    input  logic          vclk,
    input  logic          dValid_h,
    input  logic          dValid_v,
    input  logic [1:0]    pattern_sel,
    input  logic [11:0]   solid_rgb,
    output logic          hsync,
    output logic          vsync,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [7:0]    frame_cnt,
    output logic          timing_err
);

    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic          w_active;
    logic          w_armed;
    logic          w_frame_end;
    logic [7:0]    w_frame_cnt;
    logic          w_timing_err;

    vga_pixel_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CW       (CW)
    ) u_counter (
        .i_clk        (pixelClk),
        .i_rst_n      (rst),
        .i_dvalid_h   (dValid_h),
        .i_dvalid_v   (dValid_v),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_active     (w_active),
        .o_armed      (w_armed),
        .o_frame_end  (w_frame_end),
        .o_frame_cnt  (w_frame_cnt),
        .o_timing_err (w_timing_err)
    );

    pattern_e      r_pat;
    rgb444_t       r_solid;

    logic [CW-1:0] r_s1_x;
    logic [CW-1:0] r_s1_y;
    logic          r_s1_active;
    logic          r_s1_hs;
    logic          r_s1_vs;

    logic          r_hs;
    logic          r_vs;
    rgb444_t       r_rgb;
    logic [CW-1:0] r_pix_x;
    logic [CW-1:0] r_pix_y;

    logic [2:0]    w_bar_idx;
    rgb444_t       w_rgb;

    // Bar index by threshold compares so x/BAR_W never becomes a divider.
    always_comb begin
        w_bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (r_s1_x >= CW'(k * BAR_W)) begin
                w_bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        w_rgb = '0;
        if (r_s1_active) begin
            case (r_pat)
                PAT_BARS:  w_rgb = bar_colour(w_bar_idx);
                PAT_CHECK: w_rgb = (r_s1_x[CHECK_BIT] ^ r_s1_y[CHECK_BIT]) ? 12'h000 : 12'hFFF;
                PAT_GRAD: begin
                    w_rgb.r = r_s1_x[9:6];
                    w_rgb.g = r_s1_y[8:5];
                    w_rgb.b = w_frame_cnt[7:4];
                end
                PAT_SOLID: w_rgb = r_solid;
                default:   w_rgb = '0;
            endcase
        end
    end

    always_ff @(posedge pixelClk) begin
        if (!rst) begin
            r_pat       <= PAT_BARS;
            r_solid     <= '0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_active <= 1'b0;
            r_s1_hs     <= SYNC_IDLE;
            r_s1_vs     <= SYNC_IDLE;
            r_hs        <= SYNC_IDLE;
            r_vs        <= SYNC_IDLE;
            r_rgb       <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
        end else begin
            // Mode changes only land at a frame boundary so a frame never mixes patterns.
            if (w_frame_end) begin
                r_pat   <= pattern_e'(pattern_sel);
                r_solid <= rgb444_t'(solid_rgb);
            end

            r_s1_x      <= w_x;
            r_s1_y      <= w_y;
            r_s1_active <= w_active & w_armed;
            r_s1_hs     <= hclk;
            r_s1_vs     <= vclk;

            r_hs    <= r_s1_hs;
            r_vs    <= r_s1_vs;
            r_rgb   <= w_rgb;
            r_pix_x <= r_s1_x;
            r_pix_y <= r_s1_y;
        end
    end

    assign hsync      = r_hs;
    assign vsync      = r_vs;
    assign red        = r_rgb.r;
    assign green      = r_rgb.g;
    assign blue       = r_rgb.b;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign frame_cnt  = w_frame_cnt;
    assign timing_err = w_timing_err;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: randomized raster stimulus, reference model of the pattern rules,
// expected outputs queued per input cycle and checked by a separate monitor.
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CW       = 10;
    localparam int BAR_W    = 80;
    localparam logic [33:0] RST_ENTRY = {1'b1, 1'b1, 12'h000, 10'd0, 10'd0};

    logic          clk = 1'b0;
    logic          rst;
    logic          hclk;
    logic          vclk;
    logic          dvh;
    logic          dvv;
    logic [1:0]    psel;
    logic [11:0]   solid;
    logic          hsync;
    logic          vsync;
    logic [3:0]    red;
    logic [3:0]    green;
    logic [3:0]    blue;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [7:0]    frame_cnt;
    logic          timing_err;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .pixelClk    (clk),
        .rst         (rst),
        .hclk        (hclk),
        .vclk        (vclk),
        .dValid_h    (dvh),
        .dValid_v    (dvv),
        .pattern_sel (psel),
        .solid_rgb   (solid),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_cnt   (frame_cnt),
        .timing_err  (timing_err)
    );

    logic [33:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, stepped once per driven cycle.
    int          m_run   = 0;
    int          m_lines = 0;
    bit          m_prev_dvh = 0;
    bit          m_prev_dvv = 0;
    bit          m_armed = 0;
    bit          m_err   = 0;
    int          m_frame = 0;
    int          m_pat   = 0;
    logic [11:0] m_solid = '0;
    logic [1:0]  next_psel = 2'd0;
    logic [11:0] next_solid = '0;
    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic logic [11:0] ref_colour(input int x, input int y);
        logic [11:0] c;
        case (m_pat)
            0:       c = bar_tab[x / BAR_W];
            1:       c = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 12'h000 : 12'hFFF;
            2:       c = {4'((x >> 6) & 15), 4'((y >> 5) & 15), 4'((m_frame >> 4) & 15)};
            default: c = m_solid;
        endcase
        return c;
    endfunction

    task automatic drive(input bit r, input bit hc, input bit vc, input bit dh, input bit dv);
        int x;
        int y;
        bit act;
        logic [11:0] c;
        @(negedge clk);
        rst = r; hclk = hc; vclk = vc; dvh = dh; dvv = dv;
        psel = next_psel; solid = next_solid;
        if (!r) begin
            // Reset blanks the output for this cycle and the one already in flight.
            if (exp_q.size() > 0) exp_q[exp_q.size()-1] = RST_ENTRY;
            exp_q.push_back(RST_ENTRY);
            m_run = 0; m_lines = 0; m_prev_dvh = 0; m_prev_dvv = 0;
            m_armed = 0; m_err = 0; m_frame = 0; m_pat = 0; m_solid = '0;
            return;
        end
        x   = (m_run < H_ACTIVE) ? m_run : H_ACTIVE - 1;
        y   = (m_lines < V_ACTIVE) ? m_lines : V_ACTIVE - 1;
        act = dh && dv;
        c   = (act && m_armed) ? ref_colour(x, y) : 12'h000;
        exp_q.push_back({hc, vc, c, CW'(x), CW'(y)});
        if (act && (m_run >= H_ACTIVE || m_lines >= V_ACTIVE)) m_err = 1;
        if (!dh) m_run = 0;
        else if (act) m_run = (m_run + 1 > H_ACTIVE) ? H_ACTIVE : m_run + 1;
        if (!dv) m_lines = 0;
        else if (m_prev_dvh && !dh) m_lines = (m_lines + 1 > V_ACTIVE) ? V_ACTIVE : m_lines + 1;
        if (m_prev_dvv && !dv) begin
            m_armed = 1;
            m_frame = (m_frame + 1) % 256;
            m_pat   = int'(psel);
            m_solid = solid;
        end
        m_prev_dvh = dh;
        m_prev_dvv = dv;
    endtask

    // 16 blanking cycles carrying the hsync pulse, then the active window.
    task automatic do_line(input int act_len, input bit dv, input bit vc, input int rst_at);
        for (int i = 0; i < 16; i++) drive(1, !(i >= 4 && i < 10), vc, 0, dv);
        for (int i = 0; i < act_len; i++) drive(i != rst_at, 1, vc, 1, dv);
    endtask

    task automatic vblank();
        do_line(8, 0, 1, -1);
        do_line(8, 0, 0, -1);
        do_line(8, 0, 1, -1);
    endtask

    task automatic do_frame(input int nlines, input int lmin, input int lmax,
                            input int chg_line, input logic [1:0] chg_psel,
                            input logic [11:0] chg_solid);
        for (int l = 0; l < nlines; l++) begin
            if (l == chg_line) begin
                next_psel  = chg_psel;
                next_solid = chg_solid;
            end
            do_line((l == 0) ? lmax : int'($urandom_range(lmax, lmin)), 1, 1, -1);
        end
        vblank();
    endtask

    // Monitor: status outputs every cycle, pixel outputs two cycles after their input.
    initial begin
        logic [33:0] e;
        logic [33:0] got;
        forever begin
            @(posedge clk);
            #2;
            n_tests++;
            if (frame_cnt !== 8'(m_frame) || timing_err !== m_err) begin
                n_fail++;
                if (n_fail <= 30)
                    $display("FAIL status t=%0t frame_cnt=%0d exp=%0d timing_err=%b exp=%b",
                             $time, frame_cnt, m_frame, timing_err, m_err);
            end
            if (exp_q.size() >= 2) begin
                e   = exp_q.pop_front();
                got = {hsync, vsync, red, green, blue, pix_x, pix_y};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    if (n_fail <= 30)
                        $display("FAIL pixel t=%0t hs/vs=%b%b rgb=%h x=%0d y=%0d exp hs/vs=%b%b rgb=%h x=%0d y=%0d",
                                 $time, got[33], got[32], got[31:20], got[19:10], got[9:0],
                                 e[33], e[32], e[31:20], e[19:10], e[9:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; hclk = 1'b1; vclk = 1'b1; dvh = 1'b0; dvv = 1'b1;
        psel = 2'd0; solid = '0;

        // Reset held while timing keeps running.
        for (int i = 0; i < 10; i++) drive(0, (i % 4) < 2, 1, i >= 5, 1);

        // Partial frame after reset stays black, then the frame edge arms rendering.
        for (int l = 0; l < 3; l++) do_line(50, 1, 1, -1);
        vblank();

        // Bars with a full-width line; checker requested mid-frame takes effect next frame.
        do_frame(3, 100, 640, 1, 2'd1, 12'h000);
        // Checker over 36 lines; solid 0A5 requested at line 20.
        do_frame(36, 33, 80, 20, 2'd3, 12'h0A5);
        // Solid frame, then gradient.
        do_frame(4, 20, 640, 2, 2'd2, 12'($urandom));

        // Many short frames with random modes so frame_cnt climbs past 16.
        for (int f = 0; f < 20; f++)
            do_frame(3, 4, 40, 1, (f == 19) ? 2'd2 : 2'($urandom_range(3, 0)), 12'($urandom));
        do_frame(2, 640, 640, 0, 2'd0, 12'h000);

        // Over-long line saturates x and sets the sticky error.
        do_line(700, 1, 1, -1);
        vblank();
        do_frame(2, 10, 100, 0, 2'd1, 12'h000);

        // Reset pulse at (300,100), then the rest of that frame is black.
        for (int l = 0; l < 100; l++) do_line(8, 1, 1, -1);
        do_line(400, 1, 1, 300);
        for (int l = 0; l < 3; l++) do_line(50, 1, 1, -1);
        next_psel = 2'd1;
        vblank();
        do_frame(34, 33, 640, 5, 2'd0, 12'h000);

        // Frame taller than V_ACTIVE saturates y and sets the error.
        for (int l = 0; l < 482; l++) do_line(4, 1, 1, -1);
        vblank();

        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
